// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU/STATUS write-back stage: opcodes, FSM states, flag bit positions.
package alu_wb_stage_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_IOR  = 4'd3,
    OP_XOR  = 4'd4,
    OP_COM  = 4'd5,
    OP_INC  = 4'd6,
    OP_DEC  = 4'd7,
    OP_RLF  = 4'd8,
    OP_RRF  = 4'd9,
    OP_SWAP = 4'd10,
    OP_MOVF = 4'd11,
    OP_MOVW = 4'd12,
    OP_CLR  = 4'd13
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Flag vectors are ordered {Z, DC, C}, matching status_in.
  localparam int FLAG_C  = 0;
  localparam int FLAG_DC = 1;
  localparam int FLAG_Z  = 2;

endpackage

// File: rtl/alu_wb_stage_core.sv
// Combinational ALU: result, candidate flags and the mask of flags each opcode is allowed to update.
module alu_wb_stage_core
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             dc,
  output logic             z,
  output logic [2:0]       mask
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = '0;
    y    = b;
    c    = c_in;
    dc   = 1'b0;
    mask = 3'b000;
    case (opcode_t'(op))
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b};
        y    = sum[WIDTH-1:0];
        c    = sum[WIDTH];
        // carry into bit 4 recovered from the sum bit and both operand bits
        dc   = y[4] ^ a[4] ^ b[4];
        mask = 3'b111;
      end
      OP_SUB: begin
        sum  = {1'b0, b} + {1'b0, ~a} + (WIDTH+1)'(1);
        y    = sum[WIDTH-1:0];
        c    = sum[WIDTH];
        dc   = y[4] ^ ~a[4] ^ b[4];
        mask = 3'b111;
      end
      OP_AND:  begin y = a & b;  mask = 3'b100; end
      OP_IOR:  begin y = a | b;  mask = 3'b100; end
      OP_XOR:  begin y = a ^ b;  mask = 3'b100; end
      OP_COM:  begin y = ~b;     mask = 3'b100; end
      OP_INC:  begin y = b + WIDTH'(1); mask = 3'b100; end
      OP_DEC:  begin y = b - WIDTH'(1); mask = 3'b100; end
      OP_RLF:  begin y = {b[WIDTH-2:0], c_in}; c = b[WIDTH-1]; mask = 3'b001; end
      OP_RRF:  begin y = {c_in, b[WIDTH-1:1]}; c = b[0];       mask = 3'b001; end
      OP_SWAP: y = {b[WIDTH/2-1:0], b[WIDTH-1:WIDTH/2]};
      OP_MOVF: mask = 3'b100;
      OP_MOVW: y = a;
      OP_CLR:  begin y = '0; mask = 3'b100; end
      default: ;
    endcase
  end

  assign z = (y == '0);

endmodule

// File: rtl/alu_wb_stage.sv
// Sequenced ALU stage: latches operands, registers the result and issues a single write-back pulse.
// state | meaning: IDLE wait for start; EXEC compute and register; WB pulse write enable/done, commit flags
module alu_wb_stage
  import alu_wb_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             dest_f,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             status_load,
  input  logic [2:0]       status_in,
  output logic [WIDTH-1:0] result,
  output logic             w_write_en,
  output logic             f_write_en,
  output logic             busy,
  output logic             done,
  output logic             status_c,
  output logic             status_dc,
  output logic             status_z
);

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic             dest_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       flags_q, calc_q, mask_q;
  logic [WIDTH-1:0] core_y;
  logic             core_c, core_dc, core_z;
  logic [2:0]       core_mask;

  alu_wb_stage_core #(.WIDTH(WIDTH)) u_core (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .c_in (flags_q[FLAG_C]),
    .y    (core_y),
    .c    (core_c),
    .dc   (core_dc),
    .z    (core_z),
    .mask (core_mask)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      dest_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      result  <= '0;
      calc_q  <= '0;
      mask_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        op_q   <= opcode;
        dest_q <= dest_f;
        a_q    <= op_a;
        b_q    <= op_b;
      end
      if (state_q == ST_EXEC) begin
        result <= core_y;
        calc_q <= {core_z, core_dc, core_c};
        mask_q <= core_mask;
      end
      // a direct STATUS write overrides the ALU's flag commit
      if (status_load)
        flags_q <= status_in;
      else if (state_q == ST_WB)
        flags_q <= (mask_q & calc_q) | (~mask_q & flags_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    w_write_en = 1'b0;
    f_write_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EXEC;
      ST_EXEC: begin
        busy    = 1'b1;
        state_d = ST_WB;
      end
      ST_WB: begin
        busy       = 1'b1;
        done       = 1'b1;
        w_write_en = ~dest_q;
        f_write_en = dest_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign status_c  = flags_q[FLAG_C];
  assign status_dc = flags_q[FLAG_DC];
  assign status_z  = flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: hand-computed results, flag values and write-back timing.
module tb_alu_wb_stage;
  import alu_wb_stage_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start, dest_f, status_load;
  logic [3:0] opcode;
  logic [7:0] op_a, op_b, result;
  logic [2:0] status_in;
  logic       w_write_en, f_write_en, busy, done, status_c, status_dc, status_z;

  int n_checks = 0;
  int n_pass   = 0;

  alu_wb_stage #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .opcode      (opcode),
    .dest_f      (dest_f),
    .op_a        (op_a),
    .op_b        (op_b),
    .status_load (status_load),
    .status_in   (status_in),
    .result      (result),
    .w_write_en  (w_write_en),
    .f_write_en  (f_write_en),
    .busy        (busy),
    .done        (done),
    .status_c    (status_c),
    .status_dc   (status_dc),
    .status_z    (status_z)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] flags();
    return {status_z, status_dc, status_c};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one operation starting just after an edge; optional STATUS write during WB.
  task automatic do_op(input string tag, input logic [3:0] op, input logic dst,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_y, input logic [2:0] exp_flags,
                       input logic sl_wb = 1'b0, input logic [2:0] sl_val = 3'b000);
    opcode = op; dest_f = dst; op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_exec_busy"}, {busy, done, w_write_en, f_write_en}, 4'b1000);
    tick();
    chk({tag, "_result"}, result, exp_y);
    chk({tag, "_wb"}, {busy, done, w_write_en, f_write_en}, {2'b11, ~dst, dst});
    if (sl_wb) begin
      status_load = 1'b1;
      status_in   = sl_val;
    end
    tick();
    status_load = 1'b0;
    chk({tag, "_flags"}, flags(), exp_flags);
    chk({tag, "_idle"}, {busy, done, w_write_en, f_write_en}, 4'b0000);
  endtask

  task automatic load_status(input logic [2:0] v);
    status_load = 1'b1;
    status_in   = v;
    tick();
    status_load = 1'b0;
  endtask

  initial begin
    int n_done, n_stray;
    reset = 1'b1; start = 1'b0; opcode = '0; dest_f = 1'b0;
    op_a = '0; op_b = '0; status_load = 1'b0; status_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_result", result, 8'h00);
    chk("reset_ctrl", {busy, done, w_write_en, f_write_en}, 4'b0000);
    chk("reset_flags", flags(), 3'b000);

    // flags are {Z, DC, C}
    do_op("add_0f_01", OP_ADD, 1'b0, 8'h0F, 8'h01, 8'h10, 3'b010);
    do_op("sub_eq",    OP_SUB, 1'b1, 8'h05, 8'h05, 8'h00, 3'b111);
    do_op("sub_borrow",OP_SUB, 1'b1, 8'h06, 8'h05, 8'hFF, 3'b000);
    load_status(3'b001);
    do_op("rlf_80",    OP_RLF, 1'b0, 8'h00, 8'h80, 8'h01, 3'b001);
    do_op("rrf_01",    OP_RRF, 1'b0, 8'h00, 8'h01, 8'h80, 3'b001);
    do_op("inc_ff",    OP_INC, 1'b0, 8'h00, 8'hFF, 8'h00, 3'b101);
    load_status(3'b000);
    do_op("clr",       OP_CLR, 1'b1, 8'h12, 8'h34, 8'h00, 3'b100);
    do_op("swap_a5",   OP_SWAP,1'b0, 8'h00, 8'hA5, 8'h5A, 3'b100);
    do_op("dec_00",    OP_DEC, 1'b0, 8'h00, 8'h00, 8'hFF, 3'b000);
    do_op("xor_ff",    OP_XOR, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'b100);
    do_op("movw_3c",   OP_MOVW,1'b0, 8'h3C, 8'h99, 8'h3C, 3'b100);
    do_op("undef_f",   4'hF,   1'b0, 8'h11, 8'h77, 8'h77, 3'b100);
    do_op("and_f0",    OP_AND, 1'b0, 8'hF0, 8'h3C, 8'h30, 3'b000);

    // start held for six edges: only two operations may complete
    n_done = 0; n_stray = 0;
    opcode = OP_ADD; dest_f = 1'b0; op_a = 8'h01; op_b = 8'h01; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 5) start = 1'b0;
      if (done) n_done++;
      if ((w_write_en || f_write_en) && !done) n_stray++;
    end
    chk("held_start_ops", n_done, 2);
    chk("held_start_stray", n_stray, 0);
    chk("held_start_result", result, 8'h02);

    // reset during EXEC aborts the write and clears everything
    load_status(3'b111);
    opcode = OP_ADD; op_a = 8'h20; op_b = 8'h30; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_in_exec", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_stray = 0;
    for (int i = 0; i < 3; i++) begin
      if (w_write_en || f_write_en || done) n_stray++;
      tick();
    end
    chk("abort_no_write", n_stray, 0);
    chk("abort_result", result, 8'h00);
    chk("abort_flags", flags(), 3'b000);

    // STATUS write coinciding with WB wins over the ALU flags
    do_op("add_sl_wb", OP_ADD, 1'b0, 8'h01, 8'h01, 8'h02, 3'b111, 1'b1, 3'b111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
